// File: rtl/darktimer_mc.sv
// Multi-channel reload timer / interrupt peripheral for the darkriscv IO space.
// NCH channels share one microsecond prescaler; pending bits are write-1-to-clear.
module darktimer_mc #(
  parameter int NCH       = 4,
  parameter int TW        = 32,
  parameter int PRESC_RST = 49,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WR,
  input  logic          RD,
  input  logic [AW-1:0] ADDR,
  input  logic [3:0]    BE,
  input  logic [31:0]   DATAI,
  output logic [31:0]   DATAO,
  output logic          DACK,
  output logic          IRQ,
  output logic          TICK
);

  localparam int OW = AW - 2;
  localparam int CW = OW - 1;
  localparam logic [31:0] PRESC_INIT = 32'(PRESC_RST);

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [TW-1:0] f_wr_tw(input logic [TW-1:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
    logic [31:0] m;
    m = f_merge(32'(old_v), new_v, be);
    return m[TW-1:0];
  endfunction

  logic [31:0]    r_presc, r_pcnt, r_usec, r_datao;
  logic           r_dack;
  logic [NCH-1:0] r_pend, r_ien, r_en, r_mode;
  logic [TW-1:0]  r_reload [NCH];
  logic [TW-1:0]  r_cnt    [NCH];

  logic [OW-1:0]  w_woff, w_chrel;
  logic [CW-1:0]  w_ch;
  logic           w_is_ch, w_ch_cnt, w_tick;
  logic           w_wr_presc, w_wr_irq, w_wr_ctrl;
  logic [NCH-1:0] w_ch_hit, w_wr_rel, w_en_wr, w_mode_wr, w_ien_wr, w_expire, w_rise, w_w1c;
  logic [31:0]    w_irq_word, w_ctrl_word, w_irq_new, w_ctrl_new, w_rdata;
  logic           w_unused;

  // Channel windows start at word 8 (0x20), two words per channel.
  assign w_woff     = ADDR[AW-1:2];
  assign w_is_ch    = (w_woff >= OW'(8));
  assign w_chrel    = w_woff - OW'(8);
  assign w_ch       = w_chrel[OW-1:1];
  assign w_ch_cnt   = w_chrel[0];
  assign w_tick     = (r_pcnt == 32'd0);
  assign w_wr_presc = WR & ~w_is_ch & (w_woff == OW'(0));
  assign w_wr_irq   = WR & ~w_is_ch & (w_woff == OW'(2));
  assign w_wr_ctrl  = WR & ~w_is_ch & (w_woff == OW'(3));
  assign w_unused   = ^{ADDR[1:0], w_irq_new, w_ctrl_new};

  // Packed register views, byte-merged write values and per-channel events.
  always_comb begin
    w_irq_word  = 32'd0;
    w_ctrl_word = 32'd0;
    w_irq_word[16 +: NCH]  = r_ien;
    w_irq_word[0 +: NCH]   = r_pend;
    w_ctrl_word[16 +: NCH] = r_mode;
    w_ctrl_word[0 +: NCH]  = r_en;
    w_irq_new  = f_merge(w_irq_word, DATAI, BE);
    w_ctrl_new = f_merge(w_ctrl_word, DATAI, BE);
    w_ien_wr   = w_irq_new[16 +: NCH];
    w_en_wr    = w_ctrl_new[0 +: NCH];
    w_mode_wr  = w_ctrl_new[16 +: NCH];
    w_w1c      = (w_wr_irq && BE[0]) ? DATAI[NCH-1:0] : {NCH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      w_ch_hit[k] = w_is_ch & (w_ch == CW'(k));
      w_wr_rel[k] = WR & w_ch_hit[k] & ~w_ch_cnt;
      w_expire[k] = w_tick & r_en[k] & (r_cnt[k] == {TW{1'b0}});
      w_rise[k]   = w_wr_ctrl & w_en_wr[k] & ~r_en[k];
    end
  end

  // Read data mux; unmapped offsets and absent channels read as zero.
  always_comb begin
    w_rdata = 32'd0;
    if (w_is_ch) begin
      for (int k = 0; k < NCH; k++) begin
        w_rdata = w_rdata | (w_ch_hit[k] ? (w_ch_cnt ? 32'(r_cnt[k]) : 32'(r_reload[k])) : 32'd0);
      end
    end else begin
      case (w_woff)
        OW'(0):  w_rdata = r_presc;
        OW'(1):  w_rdata = r_usec;
        OW'(2):  w_rdata = w_irq_word;
        OW'(3):  w_rdata = w_ctrl_word;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // Prescaler and microsecond counter; a new PRESC is picked up at the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= PRESC_INIT;
      r_pcnt  <= PRESC_INIT;
      r_usec  <= 32'd0;
    end else begin
      if (w_wr_presc) r_presc <= f_merge(r_presc, DATAI, BE);
      if (w_tick) begin
        r_pcnt <= r_presc;
        r_usec <= r_usec + 32'd1;
      end else begin
        r_pcnt <= r_pcnt - 32'd1;
      end
    end
  end

  // Channel counters, control and pending state; expiry beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= {NCH{1'b0}};
      r_ien  <= {NCH{1'b0}};
      r_en   <= {NCH{1'b0}};
      r_mode <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
        r_reload[k] <= {TW{1'b0}};
        r_cnt[k]    <= {TW{1'b0}};
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr_rel[k]) r_reload[k] <= f_wr_tw(r_reload[k], DATAI, BE);
        if (w_rise[k]) begin
          r_cnt[k] <= r_reload[k];
        end else if (w_tick && r_en[k]) begin
          r_cnt[k] <= (r_cnt[k] == {TW{1'b0}}) ? r_reload[k] : r_cnt[k] - {{(TW-1){1'b0}}, 1'b1};
        end
        if (w_wr_ctrl) begin
          r_en[k]   <= w_en_wr[k];
          r_mode[k] <= w_mode_wr[k];
        end else if (w_expire[k] && r_mode[k]) begin
          r_en[k] <= 1'b0;
        end
        if (w_wr_irq) r_ien[k] <= w_ien_wr[k];
        if (w_expire[k]) begin
          r_pend[k] <= 1'b1;
        end else if (w_w1c[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Registered read port with one wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_datao <= 32'd0;
      r_dack  <= 1'b0;
    end else begin
      r_dack <= RD;
      if (RD) r_datao <= w_rdata;
    end
  end

  assign DATAO = r_datao;
  assign DACK  = r_dack;
  assign IRQ   = |(r_pend & r_ien);
  assign TICK  = w_tick;

endmodule
